// File: rtl/load_store_unit.sv
// rtl/load_store_unit.sv - MEM-stage load/store front end with byte masks, load stall and result formatting
module load_store_unit #(
  parameter int ADDR_BITS = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 load_en,
  input  logic                 store_en,
  input  logic [2:0]           funct3,
  input  logic [31:0]          eff_addr,
  input  logic [31:0]          store_data,
  input  logic                 mem_valid,
  input  logic [31:0]          mem_data_out,
  output logic                 request,
  output logic                 we_re,
  output logic                 load,
  output logic [3:0]           mask,
  output logic [ADDR_BITS-1:0] address,
  output logic [31:0]          data_in,
  output logic                 stall,
  output logic [31:0]          load_data,
  output logic                 load_done,
  output logic                 access_fault
);

  typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

  state_t     state;
  logic [2:0] cap_funct3;
  logic [1:0] cap_off;

  logic       illegal;
  logic       misaligned;
  logic       fault;
  logic [3:0] lane_mask;
  logic [31:0] store_lanes;
  logic       unused_addr_bits;

  assign unused_addr_bits = ^eff_addr[31:ADDR_BITS+2];

  // size 11 covers 011 and 111; 110 is the remaining unsigned-word code with no RV32 meaning
  assign illegal    = (funct3[1:0] == 2'b11) || (funct3 == 3'b110);
  assign misaligned = ((funct3[1:0] == 2'b01) && eff_addr[0]) ||
                      ((funct3[1:0] == 2'b10) && (eff_addr[1:0] != 2'b00));
  assign fault      = illegal || misaligned;

  assign lane_mask = (funct3[1:0] == 2'b00) ? (4'b0001 << eff_addr[1:0]) :
                     (funct3[1:0] == 2'b01) ? (eff_addr[1] ? 4'b1100 : 4'b0011) :
                                              4'b1111;

  assign store_lanes = (funct3[1:0] == 2'b00) ? {4{store_data[7:0]}} :
                       (funct3[1:0] == 2'b01) ? {2{store_data[15:0]}} :
                                                store_data;

  // Select the addressed byte/half from the returned word and extend it
  function automatic logic [31:0] format_load(input logic [31:0] word,
                                              input logic [2:0]  f3,
                                              input logic [1:0]  off);
    logic [31:0] byte_shift;
    logic [31:0] half_shift;
    logic [7:0]  b;
    logic [15:0] h;
    byte_shift = word >> {off, 3'b000};
    half_shift = word >> {off[1], 4'b0000};
    b = byte_shift[7:0];
    h = half_shift[15:0];
    case (f3[1:0])
      2'b00:   format_load = f3[2] ? {24'b0, b} : {{24{b[7]}}, b};
      2'b01:   format_load = f3[2] ? {16'b0, h} : {{16{h[15]}}, h};
      default: format_load = word;
    endcase
  endfunction

  // Memory request, stall and fault decode; everything is forced low while reset is held
  always_comb begin
    request      = 1'b0;
    we_re        = 1'b0;
    load         = 1'b0;
    mask         = 4'b0000;
    address      = '0;
    data_in      = 32'b0;
    stall        = 1'b0;
    access_fault = 1'b0;
    if (!rst) begin
      case (state)
        IDLE: begin
          if (load_en || store_en) begin
            if (fault) begin
              access_fault = 1'b1;
            end else begin
              request = 1'b1;
              mask    = lane_mask;
              address = eff_addr[ADDR_BITS+1:2];
              if (load_en) begin
                load  = 1'b1;
                stall = 1'b1;
              end else begin
                we_re   = 1'b1;
                data_in = store_lanes;
              end
            end
          end
        end
        WAIT:    stall = 1'b1;
        default: ;
      endcase
    end
  end

  // Load sequencing: capture size/offset on accept, format on mem_valid, pulse load_done once
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      load_data  <= 32'b0;
      load_done  <= 1'b0;
      cap_funct3 <= 3'b0;
      cap_off    <= 2'b0;
    end else begin
      case (state)
        IDLE: begin
          load_done <= 1'b0;
          if (load_en && !fault) begin
            cap_funct3 <= funct3;
            cap_off    <= eff_addr[1:0];
            state      <= WAIT;
          end
        end
        WAIT: begin
          if (mem_valid) begin
            load_data <= format_load(mem_data_out, cap_funct3, cap_off);
            load_done <= 1'b1;
            state     <= DONE;
          end
        end
        default: begin
          load_done <= 1'b0;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// tb/tb_load_store_unit.sv - directed self-checking bench for load_store_unit
module tb_load_store_unit;

  logic        clk;
  logic        rst;
  logic        load_en;
  logic        store_en;
  logic [2:0]  funct3;
  logic [31:0] eff_addr;
  logic [31:0] store_data;
  logic        mem_valid;
  logic [31:0] mem_data_out;
  logic        request;
  logic        we_re;
  logic        load;
  logic [3:0]  mask;
  logic [7:0]  address;
  logic [31:0] data_in;
  logic        stall;
  logic [31:0] load_data;
  logic        load_done;
  logic        access_fault;

  int total;
  int bad;

  load_store_unit #(.ADDR_BITS(8)) dut (
    .clk(clk), .rst(rst), .load_en(load_en), .store_en(store_en), .funct3(funct3),
    .eff_addr(eff_addr), .store_data(store_data), .mem_valid(mem_valid),
    .mem_data_out(mem_data_out), .request(request), .we_re(we_re), .load(load),
    .mask(mask), .address(address), .data_in(data_in), .stall(stall),
    .load_data(load_data), .load_done(load_done), .access_fault(access_fault)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_idle();
    load_en      = 1'b0;
    store_en     = 1'b0;
    funct3       = 3'b000;
    eff_addr     = 32'h0;
    store_data   = 32'h0;
    mem_valid    = 1'b0;
    mem_data_out = 32'h0;
  endtask

  task automatic test_reset();
    drive_idle();
    rst = 1'b1;
    load_en = 1'b1;
    funct3 = 3'b010;
    step();
    step();
    total++;
    if (load_done !== 1'b0 || load_data !== 32'h0) begin
      bad++;
      $display("FAIL reset_regs: load_done=%b load_data=%h required 0/00000000", load_done, load_data);
    end
    total++;
    if (request !== 1'b0 || stall !== 1'b0 || load !== 1'b0 || mask !== 4'b0) begin
      bad++;
      $display("FAIL reset_comb: request=%b stall=%b load=%b mask=%b required all 0", request, stall, load, mask);
    end
    rst = 1'b0;
    drive_idle();
    step();
  endtask

  task automatic test_store(input logic [2:0] f3, input logic [31:0] addr, input logic [31:0] sd,
                            input logic [3:0] exp_mask, input logic [7:0] exp_addr,
                            input logic [31:0] exp_data);
    drive_idle();
    store_en = 1'b1;
    funct3 = f3;
    eff_addr = addr;
    store_data = sd;
    #1;
    total++;
    if (request !== 1'b1 || we_re !== 1'b1 || load !== 1'b0 || stall !== 1'b0) begin
      bad++;
      $display("FAIL store_ctrl f3=%b: request=%b we_re=%b load=%b stall=%b required 1 1 0 0", f3, request, we_re, load, stall);
    end
    total++;
    if (mask !== exp_mask || address !== exp_addr) begin
      bad++;
      $display("FAIL store_mask_addr f3=%b: mask=%b address=%h required %b %h", f3, mask, address, exp_mask, exp_addr);
    end
    total++;
    if (data_in !== exp_data) begin
      bad++;
      $display("FAIL store_data f3=%b: data_in=%h required %h", f3, data_in, exp_data);
    end
    step();
    drive_idle();
    #1;
    total++;
    if (request !== 1'b0 || stall !== 1'b0 || address !== 8'h0) begin
      bad++;
      $display("FAIL store_after: request=%b stall=%b address=%h required 0 0 00", request, stall, address);
    end
  endtask

  // delay = number of cycles after accept until mem_valid is presented (1 is nominal)
  task automatic test_load(input logic [2:0] f3, input logic [31:0] addr, input logic [31:0] word,
                           input int delay, input logic with_store, input logic [31:0] exp_data);
    drive_idle();
    load_en = 1'b1;
    store_en = with_store;
    store_data = 32'h5555AAAA;
    funct3 = f3;
    eff_addr = addr;
    #1;
    total++;
    if (request !== 1'b1 || we_re !== 1'b0 || load !== 1'b1 || stall !== 1'b1 || data_in !== 32'h0) begin
      bad++;
      $display("FAIL load_accept f3=%b: request=%b we_re=%b load=%b stall=%b data_in=%h required 1 0 1 1 0",
               f3, request, we_re, load, stall, data_in);
    end
    total++;
    if (address !== addr[9:2]) begin
      bad++;
      $display("FAIL load_addr f3=%b: address=%h required %h", f3, address, addr[9:2]);
    end
    for (int i = 1; i <= delay; i++) begin
      step();
      drive_idle();
      mem_valid = (i == delay);
      mem_data_out = (i == delay) ? word : 32'hFFFF0000;
      #1;
      total++;
      if (stall !== 1'b1 || request !== 1'b0 || load_done !== 1'b0) begin
        bad++;
        $display("FAIL load_wait T+%0d: stall=%b request=%b load_done=%b required 1 0 0", i, stall, request, load_done);
      end
    end
    step();
    drive_idle();
    load_en = 1'b1;
    funct3 = 3'b010;
    eff_addr = 32'h0000_0040;
    #1;
    total++;
    if (load_done !== 1'b1 || stall !== 1'b0 || request !== 1'b0) begin
      bad++;
      $display("FAIL load_done_cycle f3=%b: load_done=%b stall=%b request=%b required 1 0 0", f3, load_done, stall, request);
    end
    total++;
    if (load_data !== exp_data) begin
      bad++;
      $display("FAIL load_data f3=%b addr=%h: load_data=%h required %h", f3, addr, load_data, exp_data);
    end
    drive_idle();
    step();
    total++;
    if (load_done !== 1'b0 || stall !== 1'b0 || load_data !== exp_data) begin
      bad++;
      $display("FAIL load_after f3=%b: load_done=%b stall=%b load_data=%h required 0 0 %h", f3, load_done, stall, load_data, exp_data);
    end
  endtask

  task automatic test_fault(input logic is_load, input logic [2:0] f3, input logic [31:0] addr);
    drive_idle();
    load_en = is_load;
    store_en = !is_load;
    funct3 = f3;
    eff_addr = addr;
    store_data = 32'h12345678;
    #1;
    total++;
    if (access_fault !== 1'b1 || request !== 1'b0 || stall !== 1'b0 || mask !== 4'b0) begin
      bad++;
      $display("FAIL fault f3=%b addr=%h: access_fault=%b request=%b stall=%b mask=%b required 1 0 0 0",
               f3, addr, access_fault, request, stall, mask);
    end
    step();
    drive_idle();
    #1;
    total++;
    if (access_fault !== 1'b0 || stall !== 1'b0 || load_done !== 1'b0) begin
      bad++;
      $display("FAIL fault_after f3=%b: access_fault=%b stall=%b load_done=%b required 0 0 0", f3, access_fault, stall, load_done);
    end
  endtask

  task automatic test_reset_in_wait();
    logic [31:0] held;
    held = load_data;
    drive_idle();
    load_en = 1'b1;
    funct3 = 3'b010;
    eff_addr = 32'h0000_000C;
    step();
    drive_idle();
    #1;
    total++;
    if (stall !== 1'b1) begin
      bad++;
      $display("FAIL rst_wait_pre: stall=%b required 1", stall);
    end
    rst = 1'b1;
    #1;
    total++;
    if (stall !== 1'b0 || request !== 1'b0) begin
      bad++;
      $display("FAIL rst_wait_comb: stall=%b request=%b required 0 0", stall, request);
    end
    step();
    rst = 1'b0;
    mem_valid = 1'b1;
    mem_data_out = 32'hABCD0123;
    #1;
    total++;
    if (stall !== 1'b0 || load_done !== 1'b0) begin
      bad++;
      $display("FAIL rst_wait_idle: stall=%b load_done=%b required 0 0", stall, load_done);
    end
    step();
    #1;
    total++;
    if (load_done !== 1'b0 || stall !== 1'b0) begin
      bad++;
      $display("FAIL rst_wait_spurious: load_done=%b stall=%b required 0 0", load_done, stall);
    end
    mem_valid = 1'b0;
    step();
    total++;
    if (load_done !== 1'b0 || load_data !== 32'h0) begin
      bad++;
      $display("FAIL rst_wait_data: load_done=%b load_data=%h required 0 00000000 (was %h)", load_done, load_data, held);
    end
  endtask

  initial begin
    total = 0;
    bad = 0;
    rst = 1'b1;
    drive_idle();
    test_reset();
    test_store(3'b010, 32'h0000_0010, 32'hDEADBEEF, 4'b1111, 8'h04, 32'hDEADBEEF);
    test_store(3'b000, 32'h0000_0013, 32'h000000A5, 4'b1000, 8'h04, 32'hA5A5A5A5);
    test_store(3'b001, 32'h0000_0022, 32'h0000BEEF, 4'b1100, 8'h08, 32'hBEEFBEEF);
    test_store(3'b001, 32'h0000_03FC, 32'h00001234, 4'b0011, 8'hFF, 32'h12341234);
    test_load(3'b000, 32'h0000_0012, 32'h12803456, 1, 1'b0, 32'hFFFFFF80);
    test_load(3'b100, 32'h0000_0012, 32'h12803456, 1, 1'b0, 32'h00000080);
    test_load(3'b001, 32'h0000_000E, 32'h80017FFF, 1, 1'b0, 32'hFFFF8001);
    test_load(3'b101, 32'h0000_000E, 32'h80017FFF, 1, 1'b0, 32'h00008001);
    test_load(3'b001, 32'h0000_000C, 32'h80017FFF, 1, 1'b0, 32'h00007FFF);
    test_load(3'b010, 32'h0000_000C, 32'h80017FFF, 1, 1'b0, 32'h80017FFF);
    test_load(3'b010, 32'h0000_000C, 32'hCAFEF00D, 1, 1'b1, 32'hCAFEF00D);
    test_load(3'b000, 32'h0000_0011, 32'h12803456, 3, 1'b0, 32'h00000034);
    test_fault(1'b1, 3'b010, 32'h0000_0011);
    test_fault(1'b0, 3'b001, 32'h0000_0021);
    test_fault(1'b1, 3'b011, 32'h0000_0000);
    test_fault(1'b0, 3'b110, 32'h0000_0004);
    test_reset_in_wait();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
- Memory-stage front end of the RV32IM pipeline, sitting directly upstream of the data memory wrapper.
- Converts a load or store from EX/MEM into one word-addressed request with a byte mask.
- Stalls the pipeline for the memory's one-cycle load latency.
- Formats returned data (byte/half select, sign/zero extension) and holds it for writeback.

Parameters:
- ADDR_BITS, 8, word-address width driven to data memory; selects eff_addr[ADDR_BITS+1:2].

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- load_en  in  1  MEM-stage instruction is a load
- store_en  in  1  MEM-stage instruction is a store
- funct3  in  3  RISC-V size/sign code
- eff_addr  in  32  byte effective address
- store_data  in  32  rs2 value
- mem_valid  in  1  memory read-data valid
- mem_data_out  in  32  memory read word
- request  out  1  memory access strobe
- we_re  out  1  1 = write, 0 = read
- load  out  1  read issued this cycle
- mask  out  4  byte-lane enables
- address  out  ADDR_BITS  word address
- data_in  out  32  lane-replicated store data
- stall  out  1  hold IF/ID/EX/MEM
- load_data  out  32  formatted load result (registered)
- load_done  out  1  one-cycle pulse, load_data fresh
- access_fault  out  1  misaligned or illegal funct3; no access made

Behaviour:
- FSM states: IDLE, WAIT, DONE.
- Reset (sync, rst=1): state=IDLE; load_data=0; load_done=0. All combinational outputs are 0 in the reset cycle.
- request, we_re, load, mask, data_in, stall and access_fault are combinational from state and inputs. They are 0 unless stated below.
- address = eff_addr[ADDR_BITS+1:2] whenever request=1. Otherwise it is 0.
- Alignment:
  - Halfword (funct3[1:0]=01) needs eff_addr[0]=0.
  - Word (10) needs eff_addr[1:0]=00.
  - funct3 011, 110, 111 are illegal for both loads and stores.
- Fault handling: in IDLE, a fault sets access_fault=1 for that cycle only. No request, no stall, state stays IDLE.
- Store in IDLE (store_en=1, load_en=0, legal) is a single cycle, with no stall and no state change:
  - Common: request=1, we_re=1, load=0.
  - SB: mask=0001<<eff_addr[1:0], data_in={4{store_data[7:0]}}.
  - SH: mask=0011 if eff_addr[1]=0, else 1100; data_in={2{store_data[15:0]}}.
  - SW: mask=1111, data_in=store_data.
- Load in IDLE (legal):
  - Outputs this cycle: request=1, we_re=0, load=1, mask as for the store of the same size, stall=1.
  - Captured this cycle: funct3 and eff_addr[1:0]. Next state WAIT.
- load_en and store_en both high: the load wins and the store is dropped.
- WAIT: stall=1, no request.
  - mem_valid=1: load_data <= format(mem_data_out, captured funct3/offset); next state DONE.
  - mem_valid=0: remain in WAIT.
- DONE: load_done=1, stall=0, next state IDLE. New load_en/store_en are ignored in DONE; that instruction is the stalled load leaving MEM.
- Formatting, with byte b=word[8*off+7:8*off] and half h=word[16*off[1]+15:16*off[1]]:
  - LB = sign-extend b; LBU = zero-extend b.
  - LH = sign-extend h; LHU = zero-extend h.
  - LW = word.
- load_data holds its value until the next completed load.
- mem_valid in IDLE or DONE is ignored.
- rst during WAIT or DONE: state returns to IDLE, load_done=0, and no pulse is produced later.
- Nominal load latency: accept cycle T, mem_valid at T+1, load_done and stall=0 at T+2.

Test Plan:
- SW eff_addr=0x0000_0010, store_data=0xDEADBEEF -> same cycle: request=1, we_re=1, mask=1111, address=0x04, data_in=0xDEADBEEF, stall=0.
- SB eff_addr=0x13, store_data=0x000000A5 -> mask=1000, address=0x04, data_in=0xA5A5A5A5.
- LB eff_addr=0x12, mem_valid at T+1 with mem_data_out=0x1280_3456:
  - stall=1 at T and T+1.
  - At T+2: load_done=1, load_data=0xFFFFFF80.
  - Same setup as LBU -> load_data=0x00000080.
- LH eff_addr=0x0E, mem_data_out=0x8001_7FFF -> load_data=0xFFFF8001. LW on the same word -> 0x80017FFF.
- Faults -> access_fault=1, request=0, stall=0:
  - LW eff_addr=0x11.
  - SH eff_addr=0x21.
  - funct3=011 load.
- Reset and spurious valid:
  - Assert rst in WAIT -> IDLE next cycle; mem_valid=1 afterwards gives no load_done.
  - Load with mem_valid delayed to T+3 -> stall held through T+3, load_done at T+4.
